btn_input_ctrl: RTL and testbench

Parametrised N-channel push-button front end for the game controller path. It replaces the fixed three-button debounce wrapper with one block that does the following per channel:
- two-flop synchronisation
- counter-based debounce
- press/release edge pulses
- long-hold detection
- auto-repeat pulses

It runs on the 1 ms tick clock and feeds the game logic (jump/left/right and future buttons). It also drives the keypad row line low.

---
 rtl/btn_input_ctrl.sv | 121 ++++++++++++
 tb/tb_btn_input_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/btn_input_ctrl.sv
// N-channel push-button front end: synchronise, debounce, edge pulses,
// long-hold detection and auto-repeat, all on the 1 ms tick clock.
module btn_input_ctrl #(
    parameter int unsigned N_BTN       = 3,
    parameter int unsigned ACTIVE_LOW  = 1,
    parameter int unsigned DEBOUNCE_MS = 8,
    parameter int unsigned HOLD_MS     = 500,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic             clk_1ms,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic             K_ROW,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_p,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] repeat_p,
    output logic             any_press
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_MS + 1);
    localparam int unsigned REP_W  = (REPEAT_MS == 0) ? 1 : $clog2(REPEAT_MS + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_MS);
    localparam logic [REP_W-1:0]  REP_LAST = REP_W'((REPEAT_MS == 0) ? 0 : REPEAT_MS - 1);

    logic [N_BTN-1:0]  raw_c;
    logic [N_BTN-1:0]  s1, s2;
    logic [DB_W-1:0]   db_cnt   [N_BTN];
    logic [HOLD_W-1:0] hold_cnt [N_BTN];
    logic [REP_W-1:0]  rep_cnt  [N_BTN];

    logic [N_BTN-1:0]  level_nxt, press_nxt, release_nxt, held_nxt, repeat_nxt;
    logic [DB_W-1:0]   db_nxt   [N_BTN];
    logic [HOLD_W-1:0] hold_nxt [N_BTN];
    logic [REP_W-1:0]  rep_nxt  [N_BTN];

    assign K_ROW = 1'b0;
    assign raw_c = (ACTIVE_LOW != 0) ? ~btn : btn;

    // Per-channel next state: debounce, edge detect, hold and repeat
    always_comb begin
        level_nxt   = level;
        press_nxt   = '0;
        release_nxt = '0;
        held_nxt    = '0;
        repeat_nxt  = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            db_nxt[i]   = '0;
            hold_nxt[i] = '0;
            rep_nxt[i]  = '0;
        end

        for (int i = 0; i < int'(N_BTN); i++) begin
            if (s2[i] != level[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    level_nxt[i] = s2[i];
                end else begin
                    db_nxt[i] = db_cnt[i] + DB_W'(1);
                end
            end

            press_nxt[i]   = level_nxt[i] & ~level[i];
            release_nxt[i] = ~level_nxt[i] & level[i];

            // Hold/repeat only advance while the press persists across this edge
            if (level[i] && level_nxt[i]) begin
                hold_nxt[i] = (hold_cnt[i] == HOLD_MAX) ? HOLD_MAX
                                                        : hold_cnt[i] + HOLD_W'(1);
                if (hold_cnt[i] != HOLD_MAX && hold_nxt[i] == HOLD_MAX) begin
                    repeat_nxt[i] = 1'b1;
                end
                if (held[i] && REPEAT_MS != 0) begin
                    if (rep_cnt[i] == REP_LAST) begin
                        rep_nxt[i]    = '0;
                        repeat_nxt[i] = 1'b1;
                    end else begin
                        rep_nxt[i] = rep_cnt[i] + REP_W'(1);
                    end
                end
            end

            held_nxt[i] = (hold_nxt[i] == HOLD_MAX);
        end
    end

    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            level     <= '0;
            press     <= '0;
            release_p <= '0;
            held      <= '0;
            repeat_p  <= '0;
            any_press <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt[i]   <= '0;
                hold_cnt[i] <= '0;
                rep_cnt[i]  <= '0;
            end
        end else begin
            s1        <= raw_c;
            s2        <= s1;
            level     <= level_nxt;
            press     <= press_nxt;
            release_p <= release_nxt;
            held      <= held_nxt;
            repeat_p  <= repeat_nxt;
            any_press <= |press_nxt;
            for (int i = 0; i < int'(N_BTN); i++) begin
                db_cnt[i]   <= db_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
                rep_cnt[i]  <= rep_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Bench for btn_input_ctrl: directed scenarios plus random button activity,
// checked every cycle against a history-based behavioural model.
module tb_btn_input_ctrl;
    localparam int N   = 3;
    localparam int DB  = 4;
    localparam int HLD = 10;
    localparam int REP = 3;

    logic         clk_1ms = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn;
    logic         K_ROW;
    logic [N-1:0] level, press, release_p, held, repeat_p;
    logic         any_press;

    int total = 0;
    int bad   = 0;

    btn_input_ctrl #(
        .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_MS(DB), .HOLD_MS(HLD), .REPEAT_MS(REP)
    ) dut (
        .clk_1ms(clk_1ms), .rst_n(rst_n), .btn(btn), .K_ROW(K_ROW),
        .level(level), .press(press), .release_p(release_p), .held(held),
        .repeat_p(repeat_p), .any_press(any_press)
    );

    always #5 clk_1ms = ~clk_1ms;

    // Model: level flips once the last DB synchronised samples (raw delayed two
    // edges) all disagree with it; hold/repeat derived from time since rise.
    logic [N-1:0] hist [$];
    logic [N-1:0] m_lvl, m_prs, m_rel, m_held, m_rep;
    int           cyc;
    int           rise_cyc [N];

    always @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < DB + 2; k++) hist.push_front('0);
            m_lvl = '0; m_prs = '0; m_rel = '0; m_held = '0; m_rep = '0;
            cyc = 0;
            for (int c = 0; c < N; c++) rise_cyc[c] = 0;
        end else begin
            cyc++;
            hist.push_front(~btn);
            void'(hist.pop_back());
            for (int c = 0; c < N; c++) begin
                logic agree;
                logic prev;
                int   dt;
                agree = 1'b1;
                for (int k = 2; k < DB + 2; k++)
                    if (hist[k][c] == m_lvl[c]) agree = 1'b0;
                prev = m_lvl[c];
                if (agree) m_lvl[c] = ~m_lvl[c];
                m_prs[c] = m_lvl[c] & ~prev;
                m_rel[c] = ~m_lvl[c] & prev;
                if (m_prs[c]) rise_cyc[c] = cyc;
                dt = cyc - rise_cyc[c];
                m_held[c] = m_lvl[c] && (dt >= HLD);
                m_rep[c]  = m_held[c] && ((dt - HLD) % REP == 0);
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"},     16'(level),     16'(m_lvl));
        chk({tag, ".press"},     16'(press),     16'(m_prs));
        chk({tag, ".release"},   16'(release_p), 16'(m_rel));
        chk({tag, ".held"},      16'(held),      16'(m_held));
        chk({tag, ".repeat"},    16'(repeat_p),  16'(m_rep));
        chk({tag, ".any_press"}, 16'(any_press), 16'(|m_prs));
        chk({tag, ".k_row"},     16'(K_ROW),     16'(0));
    endtask

    task automatic tick(input string tag, input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_1ms);
            @(negedge clk_1ms);
            check_all(tag);
        end
    endtask

    initial begin
        // 1: reset with all buttons pressed
        rst_n = 1'b0;
        btn   = 3'b000;
        #12;
        check_all("rst_hold");
        tick("rst_clk", 2);
        @(negedge clk_1ms);
        rst_n = 1'b1;
        tick("rst_rel", 5);
        tick("rst_rel5");
        chk("rst_level_r5", 16'(level), 16'h7);
        chk("rst_press_r5", 16'(press), 16'h7);
        tick("rst_after");
        chk("rst_press_r6", 16'(press), 16'h0);

        btn = 3'b111;
        tick("idle", 8);

        // 2: clean press/release on ch0
        btn[0] = 1'b0;
        tick("p0", 5);
        chk("p0_level_e4", 16'(level[0]), 16'h0);
        tick("p0");
        chk("p0_level", 16'(level[0]), 16'h1);
        chk("p0_press", 16'(press),    16'h1);
        chk("p0_any",   16'(any_press), 16'h1);
        tick("p0");
        chk("p0_press_off", 16'(press[0]), 16'h0);
        btn[0] = 1'b1;
        tick("r0", 6);
        chk("r0_release", 16'(release_p), 16'h1);
        chk("r0_level",   16'(level[0]),  16'h0);
        tick("r0", 4);

        // 3: three-sample glitch on ch1
        btn[1] = 1'b0;
        tick("gl", 3);
        btn[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick("gl");
            chk("gl_ch1", 16'({level[1], press[1], release_p[1]}), 16'h0);
        end

        // 4: hold and auto-repeat on ch2
        btn[2] = 1'b0;
        tick("h2", 6);
        chk("h2_press", 16'(press[2]), 16'h1);
        tick("h2", 9);
        chk("h2_held_early", 16'(held[2]), 16'h0);
        tick("h2");
        chk("h2_held",  16'(held[2]),     16'h1);
        chk("h2_rep0",  16'(repeat_p[2]), 16'h1);
        tick("h2", 3);
        chk("h2_rep1",  16'(repeat_p[2]), 16'h1);
        tick("h2", 3);
        chk("h2_rep2",  16'(repeat_p[2]), 16'h1);
        btn[2] = 1'b1;
        tick("h2r", 6);
        chk("h2_release", 16'(release_p[2]), 16'h1);
        chk("h2_unheld",  16'(held[2]),      16'h0);
        chk("h2_norep",   16'(repeat_p[2]),  16'h0);
        tick("h2r", 8);

        // 5: simultaneous press on ch0/ch1 and release on ch2
        btn = 3'b011;
        tick("sim_pre", 8);
        btn = 3'b100;
        tick("sim", 6);
        chk("sim_press",   16'(press),     16'h3);
        chk("sim_release", 16'(release_p), 16'h4);
        tick("sim", 3);

        // 6: reset while ch2 is held
        btn = 3'b011;
        tick("rh", 6);
        tick("rh", 12);
        chk("rh_held_pre", 16'(held[2]), 16'h1);
        rst_n = 1'b0;
        #1;
        check_all("rh_async");
        chk("rh_held_clr", 16'(held), 16'h0);
        chk("rh_rep_clr",  16'(repeat_p), 16'h0);
        tick("rh_in", 2);
        rst_n = 1'b1;
        tick("rh_out", 6);
        chk("rh_repress", 16'(press), 16'h4);
        tick("rh_out", 3);

        // Random activity: occasional toggles give a mix of glitches and long holds
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = int'($urandom_range(0, N - 1));
                btn[b] = ~btn[b];
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
